// File: rtl/geofence_seq.sv
// geofence_seq -- job sequencer in front of a point-in-polygon geofence core.
//
// For every object of a job it fetches 7 coordinate words (test point plus
// six fence vertices) from the coordinate memory, streams them one per
// cycle into the core while the core is out of reset, then waits for the
// core verdict (or gives up after 256 wait cycles) and records it.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start, obj_num    job request (sampled in IDLE) and object count 0..16
//                     (anything above 16 is clamped to 16)
//   busy, done        job in progress / one-cycle end-of-job pulse
//   mem_rd, mem_addr  memory read strobe and word address (obj*7+k)
//   mem_x, mem_y      memory read data, one cycle after mem_rd
//   gf_rst            registered reset to the core (1 = hold core in reset)
//   gf_X, gf_Y        coordinate stream to the core (0 when not streaming)
//   gf_valid          core result strobe, honoured only in WAIT
//   gf_is_inside      core verdict accompanying gf_valid
//   inside_map        verdict bit per object of the current/last job
//   inside_cnt        number of inside verdicts in the current/last job
//   timeout_err       sticky: some object of the job timed out
module geofence_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  obj_num,
  output logic        busy,
  output logic        done,
  output logic        mem_rd,
  output logic [6:0]  mem_addr,
  input  logic [9:0]  mem_x,
  input  logic [9:0]  mem_y,
  output logic        gf_rst,
  output logic [9:0]  gf_X,
  output logic [9:0]  gf_Y,
  input  logic        gf_valid,
  input  logic        gf_is_inside,
  output logic [15:0] inside_map,
  output logic [4:0]  inside_cnt,
  output logic        timeout_err
);

  localparam int        WORDS      = 7;        // words per object
  localparam logic [3:0] FETCH_LAST = 4'd7;    // 7 reads + 1 trailing capture
  localparam logic [3:0] STRM_LAST  = 4'd6;
  localparam logic [8:0] WAIT_LIMIT = 9'd255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t state, stateNext;

  logic [3:0] phase;                 // cycle index inside FETCH / STREAM
  logic [8:0] waitCnt;               // cycles spent in WAIT for this object
  logic [4:0] objIdx;                // object currently being processed
  logic [4:0] objTotal;              // clamped object count of this job
  logic [WORDS-1:0][9:0] bufX;       // fetched words, entry k = word k
  logic [WORDS-1:0][9:0] bufY;

  logic       accept;                // start taken this cycle
  logic       timeoutHit;            // WAIT ran out without a verdict
  logic       objEnd;                // current object finishes this cycle
  logic       lastObj;               // current object is the last of the job
  logic [2:0] capIdx;                // buffer entry written this FETCH cycle
  logic [4:0] objClamp;

  // --------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------
  always_comb begin
    accept     = (state == IDLE) && start;
    timeoutHit = (state == WAIT) && !gf_valid && (waitCnt == WAIT_LIMIT);
    objEnd     = (state == WAIT) && (gf_valid || timeoutHit);
    // widened so objIdx+1 cannot wrap when compared against 16
    lastObj    = ({1'b0, objIdx} + 6'd1) >= {1'b0, objTotal};
    // read data for word k arrives in FETCH cycle k+1
    capIdx     = phase[2:0] - 3'd1;
    objClamp   = (obj_num > 5'd16) ? 5'd16 : obj_num;
  end

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // --------------------------------------------------------------------
  // Next state and Moore outputs
  // --------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    gf_X      = '0;
    gf_Y      = '0;
    unique case (state)
      IDLE: begin
        if (start) stateNext = (obj_num == 5'd0) ? FIN : FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (phase < 4'd7) begin
          mem_rd   = 1'b1;
          mem_addr = 7'(objIdx) * 7'd7 + 7'(phase);
        end
        if (phase == FETCH_LAST) stateNext = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        gf_X = bufX[phase[2:0]];
        gf_Y = bufY[phase[2:0]];
        if (phase == STRM_LAST) stateNext = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (objEnd) stateNext = lastObj ? FIN : FETCH;
      end
      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // Phase and wait counters
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase   <= '0;
      waitCnt <= '0;
    end else begin
      // phase restarts on every state change, so each FETCH/STREAM
      // visit counts from 0
      if ((state == FETCH || state == STREAM) && (stateNext == state))
        phase <= phase + 4'd1;
      else
        phase <= '0;
      if (state == WAIT && !objEnd) waitCnt <= waitCnt + 9'd1;
      else                          waitCnt <= '0;
    end
  end

  // --------------------------------------------------------------------
  // Fetch buffer
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bufX <= '0;
      bufY <= '0;
    end else if (state == FETCH && phase != 4'd0) begin
      bufX[capIdx] <= mem_x;
      bufY[capIdx] <= mem_y;
    end
  end

  // --------------------------------------------------------------------
  // Core reset: released on the edge into STREAM, re-asserted on the
  // edge that closes the object, so the core only ever sees a complete
  // freshly fetched coordinate set.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     gf_rst <= 1'b1;
    else if (state == FETCH && stateNext == STREAM) gf_rst <= 1'b0;
    else if (objEnd)                               gf_rst <= 1'b1;
  end

  // --------------------------------------------------------------------
  // Job bookkeeping and results
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      objIdx      <= '0;
      objTotal    <= '0;
      inside_map  <= '0;
      inside_cnt  <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      objIdx      <= '0;
      objTotal    <= objClamp;
      inside_map  <= '0;
      inside_cnt  <= '0;
      timeout_err <= 1'b0;
    end else if (objEnd) begin
      // a timed-out object records 0 because gf_valid is low that cycle
      inside_map[objIdx[3:0]] <= gf_valid & gf_is_inside;
      if (gf_valid && gf_is_inside) inside_cnt <= inside_cnt + 5'd1;
      if (timeoutHit)               timeout_err <= 1'b1;
      objIdx <= objIdx + 5'd1;
    end
  end

endmodule

// File: tb/tb_geofence_seq.sv
module tb_geofence_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  obj_num = '0;
  logic        busy, done, mem_rd;
  logic [6:0]  mem_addr;
  logic [9:0]  mem_x = '0;
  logic [9:0]  mem_y = '0;
  logic        gf_rst;
  logic [9:0]  gf_X, gf_Y;
  logic        gf_valid = 1'b0;
  logic        gf_is_inside = 1'b0;
  logic [15:0] inside_map;
  logic [4:0]  inside_cnt;
  logic        timeout_err;

  geofence_seq dut (
    .clk(clk), .reset(reset), .start(start), .obj_num(obj_num),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .gf_rst(gf_rst), .gf_X(gf_X), .gf_Y(gf_Y),
    .gf_valid(gf_valid), .gf_is_inside(gf_is_inside),
    .inside_map(inside_map), .inside_cnt(inside_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // coordinate memory and per-object core behaviour
  logic [9:0] memX [0:111];
  logic [9:0] memY [0:111];
  int lat     [0:15];
  bit verdict [0:15];
  bit noResp  [0:15];
  bit strayEn = 1'b0;

  int rdCnt = 0;
  int maxAddr = 0;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_x <= memX[mem_addr];
      mem_y <= memY[mem_addr];
      rdCnt <= rdCnt + 1;
      if (mem_addr == 7'd0)                maxAddr <= 0;
      else if (int'(mem_addr) > maxAddr)   maxAddr <= int'(mem_addr);
    end
  end

  // core model: n counts cycles since gf_rst fell (n=0..6 stream, n>=7 wait)
  int n = 0, fc = 0, curObj = 0;
  bit prevRd = 1'b0;
  always @(negedge clk) begin
    if (mem_rd && !prevRd) fc = 0; else fc++;
    prevRd = mem_rd;
    if (mem_rd && (int'(mem_addr) % 7 == 0)) curObj = int'(mem_addr) / 7;
    if (gf_rst) begin
      n = 0;
      gf_valid = 1'b0;
    end else begin
      if (n == 0) chk("gfRstFallCycle", fc, 8);
      if (n < 7) begin
        chk("streamX", gf_X, memX[curObj*7+n]);
        chk("streamY", gf_Y, memY[curObj*7+n]);
      end
      gf_valid = ((n == 6 + lat[curObj]) && !noResp[curObj]) || (strayEn && n == 3);
      gf_is_inside = verdict[curObj];
      n++;
    end
  end

  task automatic startJob(input logic [4:0] num);
    start = 1'b1;
    obj_num = num;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("doneSeen", done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, base;
    bit sawDone;
    logic [15:0] hexX [0:6];
    logic [15:0] hexY [0:6];
    // test point (300,300) and a convex hexagon around it
    hexX = '{300, 400, 350, 250, 200, 250, 350};
    hexY = '{300, 300, 387, 387, 300, 213, 213};
    for (int a = 0; a < 112; a++) begin
      memX[a] = 10'(a * 3 + 7);
      memY[a] = 10'(900 - a);
    end
    for (int a = 0; a < 7; a++) begin
      memX[a] = hexX[a][9:0];
      memY[a] = hexY[a][9:0];
    end
    for (int i = 0; i < 16; i++) begin
      lat[i] = 1; verdict[i] = 1'b0; noResp[i] = 1'b0;
    end

    // reset state
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rstBusy", busy, 1'b0);
    chk("rstDone", done, 1'b0);
    chk("rstMemRd", mem_rd, 1'b0);
    chk("rstGfRst", gf_rst, 1'b1);
    chk("rstMap", inside_map, 16'h0);
    chk("rstCnt", inside_cnt, 5'd0);
    chk("rstTo", timeout_err, 1'b0);
    chk("rstAddr", mem_addr, 7'd0);
    chk("rstGfX", gf_X, 10'd0);
    reset = 1'b0;
    @(negedge clk);

    // single object, verdict inside after 20 wait cycles
    lat[0] = 20; verdict[0] = 1'b1;
    startJob(5'd1);
    chk("f0Busy", busy, 1'b1);
    chk("f0MemRd", mem_rd, 1'b1);
    chk("f0Addr", mem_addr, 7'd0);
    chk("f0GfRst", gf_rst, 1'b1);
    waitDone(100, c);
    chk("oneLatency", c, 35);   // 8 + 7 + 20
    chk("finBusy", busy, 1'b0);
    @(negedge clk);
    chk("donePulse", done, 1'b0);
    chk("oneMap", inside_map, 16'h0001);
    chk("oneCnt", inside_cnt, 5'd1);
    chk("oneTo", timeout_err, 1'b0);
    repeat (3) @(negedge clk);
    chk("idleHoldMap", inside_map, 16'h0001);

    // full job, alternating verdicts, latencies 1,4,7,10 and stray valids in STREAM
    for (int i = 0; i < 16; i++) begin
      verdict[i] = (i % 2 == 0);
      lat[i] = 1 + (i % 4) * 3;
    end
    strayEn = 1'b1;
    startJob(5'd16);
    waitDone(1000, c);
    chk("fullLatency", c, 328);  // 16*15 + 4*(1+4+7+10)
    chk("fullMap", inside_map, 16'h5555);
    chk("fullCnt", inside_cnt, 5'd8);
    chk("fullTo", timeout_err, 1'b0);
    chk("fullMaxAddr", maxAddr, 111);
    strayEn = 1'b0;
    @(negedge clk);

    // obj_num=20 clamps to 16; start pulsed mid-job is ignored
    for (int i = 0; i < 16; i++) begin
      verdict[i] = 1'b1; lat[i] = 1;
    end
    startJob(5'd20);
    repeat (50) @(negedge clk);
    start = 1'b1; obj_num = 5'd1;
    @(negedge clk);
    start = 1'b0;
    chk("busyIgnStart", busy, 1'b1);
    waitDone(1000, c);
    chk("clampLatency", c + 51, 256);  // 16 * (15 + 1)
    chk("clampMap", inside_map, 16'hFFFF);
    chk("clampCnt", inside_cnt, 5'd16);
    chk("clampMaxAddr", maxAddr, 111);
    @(negedge clk);

    // timeout on object 2 of 3
    lat[0] = 3; lat[1] = 3; lat[2] = 3;
    noResp[2] = 1'b1;
    startJob(5'd3);
    waitDone(1000, c);
    chk("toLatency", c, 307);  // 18 + 18 + (15 + 256)
    chk("toErr", timeout_err, 1'b1);
    chk("toMap", inside_map, 16'h0003);
    chk("toCnt", inside_cnt, 5'd2);
    noResp[2] = 1'b0;
    @(negedge clk);

    // obj_num=0: straight to FIN, results cleared, no reads
    base = rdCnt;
    startJob(5'd0);
    chk("zeroDone", done, 1'b1);
    chk("zeroBusy", busy, 1'b0);
    chk("zeroMap", inside_map, 16'h0);
    chk("zeroTo", timeout_err, 1'b0);
    chk("zeroCnt", inside_cnt, 5'd0);
    @(negedge clk);
    chk("zeroDoneOff", done, 1'b0);
    chk("zeroNoRead", rdCnt - base, 0);

    // reset in the middle of STREAM
    lat[0] = 5; verdict[0] = 1'b1;
    startJob(5'd1);
    repeat (10) @(negedge clk);   // STREAM cycle 2
    #1 reset = 1'b1;
    #1;
    chk("midBusy", busy, 1'b0);
    chk("midDone", done, 1'b0);
    chk("midMemRd", mem_rd, 1'b0);
    chk("midGfRst", gf_rst, 1'b1);
    chk("midGfX", gf_X, 10'd0);
    chk("midGfY", gf_Y, 10'd0);
    chk("midAddr", mem_addr, 7'd0);
    chk("midMap", inside_map, 16'h0);
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    if (done) sawDone = 1'b1;
    chk("midNoDone", sawDone, 1'b0);
    startJob(5'd1);
    waitDone(100, c);
    chk("postRstLatency", c, 20);  // 8 + 7 + 5
    @(negedge clk);
    chk("postRstMap", inside_map, 16'h0001);
    chk("postRstCnt", inside_cnt, 5'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
